// File: rtl/letter_template_matcher.sv
// letter_template_matcher: latches a 16x16 binary image, requests a 26-letter template sweep,
// and reports the letter with the smallest Hamming distance. Optional macro: LETTER_MATCH_TIMEOUT_EN.
module letter_template_matcher #(
  parameter int NUM_LETTERS = 26,
  parameter int ROWS        = 16,
  parameter int WIDTH       = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ROWS*WIDTH-1:0]   i_image,
  input  logic                    i_tpl_valid,
  input  logic [WIDTH-1:0]        i_tpl_data,
  output logic                    o_recog_req,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4:0]              o_letter,
  output logic [8:0]              o_distance,
  output logic                    o_timeout
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int LET_W  = 5;
  localparam int DIST_W = 9;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACCUM, S_DONE} state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  state_t                  r_state;
  logic [ROWS*WIDTH-1:0]   r_img;
  logic [ROW_W-1:0]        r_row;
  logic [LET_W-1:0]        r_let;
  logic [DIST_W-1:0]       r_acc;
  logic [DIST_W-1:0]       r_best_dist;
  logic [LET_W-1:0]        r_best_let;
  logic                    r_done;

  logic                    w_start_ok;
  logic [WIDTH-1:0]        w_img_row;
  logic [CNT_W-1:0]        w_row_dist;
  logic [DIST_W-1:0]       w_tot;
  logic                    w_last_row;
  logic                    w_last_let;

  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_img_row  = r_img[r_row*WIDTH +: WIDTH];
  assign w_row_dist = popcount(i_tpl_data ^ w_img_row);
  assign w_tot      = r_acc + DIST_W'(w_row_dist);
  assign w_last_row = (r_row == ROW_W'(ROWS - 1));
  assign w_last_let = (r_let == LET_W'(NUM_LETTERS - 1));

  // Image is pure data: loaded on an accepted start, never reset.
  always_ff @(posedge i_clk) begin
    if (w_start_ok) r_img <= i_image;
  end

`ifdef LETTER_MATCH_TIMEOUT_EN
  logic [11:0] r_idle;
  logic        r_timeout;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_let       <= '0;
      r_acc       <= '0;
      r_best_dist <= '0;
      r_best_let  <= '0;
      r_done      <= 1'b0;
`ifdef LETTER_MATCH_TIMEOUT_EN
      r_idle      <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_row       <= '0;
            r_let       <= '0;
            r_acc       <= '0;
            r_best_dist <= '1;
            r_best_let  <= '0;
            r_state     <= S_REQ;
`ifdef LETTER_MATCH_TIMEOUT_EN
            r_idle      <= '0;
            r_timeout   <= 1'b0;
`endif
          end
        end
        S_REQ: r_state <= S_ACCUM;
        S_ACCUM: begin
          if (i_tpl_valid) begin
`ifdef LETTER_MATCH_TIMEOUT_EN
            r_idle <= '0;
`endif
            if (!w_last_row) begin
              r_acc <= w_tot;
              r_row <= r_row + 1'b1;
            end else begin
              // Strict compare so ties keep the earlier (lower) letter.
              if (w_tot < r_best_dist) begin
                r_best_dist <= w_tot;
                r_best_let  <= r_let;
              end
              r_acc <= '0;
              r_row <= '0;
              r_let <= r_let + 1'b1;
              if (w_last_let) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
`ifdef LETTER_MATCH_TIMEOUT_EN
          else if (r_idle == 12'hFFF) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_recog_req = (r_state == S_REQ);
  assign o_busy      = (r_state == S_REQ) || (r_state == S_ACCUM);
  assign o_done      = r_done;
  assign o_letter    = r_best_let;
  assign o_distance  = r_best_dist;
`ifdef LETTER_MATCH_TIMEOUT_EN
  assign o_timeout   = r_timeout;
`else
  assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_letter_template_matcher.sv
// Bench for letter_template_matcher: table-driven sweeps with a result scoreboard,
// plus hand-written reset-mid-sweep and idle-timeout sequences.
module tb_letter_template_matcher;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] img;
  logic         tv;
  logic [15:0]  td;
  logic         req, busy, done, tmo;
  logic [4:0]   let_o;
  logic [8:0]   dist_o;

  always #5 clk = ~clk;

  letter_template_matcher dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_image(img),
    .i_tpl_valid(tv), .i_tpl_data(td),
    .o_recog_req(req), .o_busy(busy), .o_done(done),
    .o_letter(let_o), .o_distance(dist_o), .o_timeout(tmo)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int done_cnt = 0;

  typedef struct { logic [4:0] l; logic [8:0] d; logic t; } exp_t;
  exp_t sb[$];

  typedef struct {
    int         mode;
    int         gap;
    bit         burst;
    bit         mid_start;
    bit         start_last;
    bit         use_model;
    logic [4:0] l;
    logic [8:0] d;
  } vec_t;

  logic [15:0]  tpl [0:415];
  logic [255:0] cur_img;

  always @(negedge clk) begin
    if (req)  req_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build(input int mode);
    case (mode)
      0, 1:    cur_img = '0;
      2, 3:    cur_img = '1;
      default: for (int i = 0; i < 8; i++) cur_img[i*32 +: 32] = $urandom;
    endcase
    for (int l = 0; l < 26; l++)
      for (int r = 0; r < 16; r++)
        case (mode)
          0: tpl[l*16+r] = (l == 7) ? 16'h0000 : 16'hFFFF;
          1: tpl[l*16+r] = (r < 2) ? 16'hFFFF : (r == 2) ? 16'h00FF : 16'h0000;
          2: tpl[l*16+r] = (l == 25 && r == 0) ? 16'hFFFF : 16'h0000;
          3: tpl[l*16+r] = 16'h0000;
          default: tpl[l*16+r] = cur_img[r*16 +: 16] ^
                                 16'($urandom & $urandom & $urandom);
        endcase
  endtask

  task automatic model(output exp_t e);
    int best, s;
    best = 1000;
    e = '{5'd0, 9'd0, 1'b0};
    for (int l = 0; l < 26; l++) begin
      s = 0;
      for (int r = 0; r < 16; r++) s += $countones(tpl[l*16+r] ^ cur_img[r*16 +: 16]);
      if (s < best) begin
        best = s;
        e.l = 5'(l);
      end
    end
    e.d = 9'(best);
  endtask

  task automatic expect_done(input string tag);
    exp_t e;
    check({tag, "_done"}, done, 1);
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_sb: got empty queue required an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_letter"}, let_o, e.l);
      check({tag, "_dist"},   dist_o, e.d);
      check({tag, "_tmo"},    tmo, e.t);
    end
  endtask

  task automatic launch();
    img = cur_img;
    req_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    img = ~cur_img;
    check("req_t1", req, 1);
    check("busy_t1", busy, 1);
    tick();
    check("req_t2", req, 0);
    check("busy_t2", busy, 1);
  endtask

  task automatic run_sweep(input string tag, input vec_t v);
    exp_t e;
    int   g;
    build(v.mode);
    if (v.use_model) model(e);
    else e = '{v.l, v.d, 1'b0};
    sb.push_back(e);
    launch();
    for (int b = 0; b < 416; b++) begin
      tv = 1'b1;
      td = tpl[b];
      if (v.mid_start && b == 50) start = 1'b1;
      if (v.start_last && b == 415) start = 1'b1;
      tick();
      tv = 1'b0;
      start = 1'b0;
      td = 16'($urandom);
      if (b < 415) begin
        g = (v.burst && b >= 160 && b < 208) ? 0 : v.gap;
        repeat (g) tick();
      end
    end
    expect_done(tag);
    check({tag, "_busy_f1"}, busy, 0);
    tick();
    check({tag, "_done_f2"}, done, 0);
    check({tag, "_req_f2"}, req, 0);
    check({tag, "_hold_letter"}, let_o, e.l);
    check({tag, "_hold_dist"}, dist_o, e.d);
    check({tag, "_req_pulses"}, req_cnt, 1);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},  req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_letter"}, let_o, 0);
    check({tag, "_dist"}, dist_o, 0);
    check({tag, "_tmo"},  tmo, 0);
  endtask

  task automatic reset_mid_sweep();
    build(4);
    launch();
    for (int b = 0; b < 200; b++) begin
      tv = 1'b1;
      td = tpl[b];
      tick();
    end
    rst = 1'b1;
    td = tpl[200];
    tick();
    rst = 1'b0;
    check_reset_outputs("rstmid");
    for (int b = 201; b < 206; b++) begin
      td = tpl[b];
      tick();
    end
    tv = 1'b0;
    check("rstmid_busy_after", busy, 0);
    check("rstmid_no_done", done_cnt, 0);
  endtask

  task automatic idle_timeout();
    int cyc;
    build(0);
`ifdef LETTER_MATCH_TIMEOUT_EN
    sb.push_back('{5'd0, 9'd256, 1'b1});
`endif
    launch();
    for (int b = 0; b < 100; b++) begin
      tv = 1'b1;
      td = tpl[b];
      tick();
    end
    tv = 1'b0;
    cyc = 0;
    while (!done && cyc < 4200) begin
      tick();
      cyc++;
    end
`ifdef LETTER_MATCH_TIMEOUT_EN
    check("tmo_latency_in_range", (cyc >= 4094 && cyc <= 4098), 1);
    expect_done("tmo");
    check("tmo_busy", busy, 0);
    tick();
    check("tmo_done_low", done, 0);
    check("tmo_held", tmo, 1);
    check("tmo_idle_no_req", req, 0);
`else
    check("notmo_no_done", done_cnt, 0);
    check("notmo_busy", busy, 1);
    check("notmo_tmo", tmo, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("notmo_rst");
`endif
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  9'd0};
    vecs[1] = '{1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  9'd40};
    vecs[2] = '{2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd25, 9'd240};
    vecs[3] = '{3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  9'd256};
    vecs[4] = '{0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7,  9'd0};
    vecs[5] = '{4, 0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  9'd0};
    vecs[6] = '{4, 1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  9'd0};

    rst = 1'b1;
    start = 1'b0;
    img = '0;
    tv = 1'b0;
    td = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    tv = 1'b1;
    td = 16'hFFFF;
    repeat (3) tick();
    tv = 1'b0;
    check("idle_beats_busy", busy, 0);
    check("idle_beats_done", done_cnt, 0);

    for (int i = 0; i < 7; i++) run_sweep($sformatf("vec%0d", i), vecs[i]);

    reset_mid_sweep();
    run_sweep("after_rst", vecs[6]);

    idle_timeout();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
